div_10: RTL and testbench
=========================

DIV_10 -- requirements
Module: div_10

Interface
REQ-001 The block SHALL have parameter N, default 10, giving the divisor/quotient/remainder width; the dividend width SHALL be 2N.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, a synchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, a request to begin a division.
REQ-005 The block SHALL have port dividend, input, 2N, the unsigned dividend (the natural operand is a multiplier product).
REQ-006 The block SHALL have port divisor, input, N, the unsigned divisor.
REQ-007 The block SHALL have port busy, output, 1, high while a division is in progress.
REQ-008 The block SHALL have port done, output, 1, a one-cycle pulse marking result valid.
REQ-009 The block SHALL have port quo, output, N, the quotient.
REQ-010 The block SHALL have port rem, output, N, the remainder.
REQ-011 The block SHALL have port dz, output, 1, the divide-by-zero flag.
REQ-012 The block SHALL have port ovf, output, 1, the quotient-overflow flag.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-014 In IDLE with start=1 at edge k, the block SHALL register dividend and divisor, clear the step counter, and enter RUN, unless an error is detected.
REQ-015 The error check at start SHALL be: divisor==0 sets dz; otherwise dividend[2N-1:N] >= divisor sets ovf; on either error the block SHALL skip RUN and enter DONE at edge k with quo = all ones and rem = 0.
REQ-016 RUN SHALL use restoring division with an (N+1)-bit partial remainder initialised to dividend[2N-1:N].
REQ-017 Each RUN step SHALL shift the next dividend bit (MSB-first, from bit N-1 down to 0) into the partial remainder.
REQ-018 Each RUN step SHALL perform a trial subtraction of divisor and, if it is non-negative, keep the difference and set the quotient bit to 1; otherwise it SHALL restore the partial remainder and set the quotient bit to 0.
REQ-019 Exactly N RUN steps SHALL occur, on edges k+1..k+N; edge k+N SHALL load quo and rem and enter DONE, giving latency N cycles from start to done for valid operands and 1 cycle for error operands.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle, and the block SHALL return to IDLE on the next edge.
REQ-021 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-022 start SHALL be ignored while busy=1; a start in the same cycle as DONE SHALL be ignored.
REQ-023 quo, rem, dz and ovf SHALL hold their last values until the next accepted start; dz and ovf SHALL be cleared on accepting a valid start.
REQ-024 For valid operands the result SHALL satisfy dividend = quo*divisor + rem and rem < divisor.

Reset
REQ-025 With rst_n=0 at an edge, the block SHALL go to IDLE and set busy, done, dz and ovf to 0 and quo and rem to 0, regardless of state.
REQ-026 Reset in the middle of RUN SHALL abort the division with no done pulse.
REQ-027 A start sampled in the same edge as rst_n=0 SHALL be ignored.

Structure
REQ-028 A shared package SHALL hold N, the state encoding constants (IDLE, RUN, DONE) and the counter width ceil(log2(N+1)).
REQ-029 The design SHALL contain one sub-module, sub_trial, an (N+1)-bit trial subtractor returning the difference and a non-negative flag, instantiated once.
REQ-030 Everything else SHALL be a single sequential always-block plus next-state logic.

Verification
REQ-031 Scenario: dividend=1000000, divisor=1000, start -> done exactly 10 cycles later, quo=1000, rem=0, dz=0, ovf=0.
REQ-032 Scenario: dividend=999999, divisor=1000 -> quo=999, rem=999.
REQ-033 Scenario: dividend=5000, divisor=0 -> done 1 cycle later, dz=1, quo=1023, rem=0.
REQ-034 Scenario: dividend=7168, divisor=7 -> ovf=1 and done after 1 cycle; dividend=7167, divisor=7 -> quo=1023, rem=6, ovf=0.
REQ-035 Scenario: start pulses during RUN -> no effect on the result or the timing; back-to-back start one cycle after done -> second result correct.
REQ-036 Scenario: rst_n=0 at RUN step 5 -> next cycle busy=0, quo=0, no done pulse; a fresh start afterwards computes correctly.

Source files
------------

// File: rtl/div_10_pkg.sv
// Shared constants for the div_10 restoring divider: default width, FSM
// state encoding and the step-counter width helper.
package div_10_pkg;

  localparam int DIV_N = 10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Counter must be able to represent 0..n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_N);

endpackage

// File: rtl/div_10_sub_trial.sv
// Trial subtractor for one restoring-division step: a - b plus a flag that
// is high when the difference is non-negative.
module sub_trial #(
  parameter int W = 11
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff,
  output logic         o_nonneg
);

  logic [W:0] w_ext;

  // One extra bit catches the borrow.
  assign w_ext    = {1'b0, i_a} - {1'b0, i_b};
  assign o_diff   = w_ext[W-1:0];
  assign o_nonneg = ~w_ext[W];

endmodule

// File: rtl/div_10.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one
// quotient bit per cycle, with divide-by-zero and quotient-overflow checks.
module div_10
  import div_10_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   quo,
  output logic [N-1:0]   rem,
  output logic           dz,
  output logic           ovf
);

  localparam int CNT_W = cnt_width(N);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [N-1:0]     r_dvd_lo;
  logic [N-1:0]     r_dvs;
  logic [N:0]       r_prem;
  logic [N-1:0]     r_qacc;
  logic [CNT_W-1:0] r_cnt;
  logic [N-1:0]     r_quo;
  logic [N-1:0]     r_rem;
  logic             r_dz;
  logic             r_ovf;

  logic [N:0]       w_shift;
  logic [N:0]       w_diff;
  logic             w_nonneg;
  logic [N:0]       w_prem_nxt;
  logic [N-1:0]     w_quo_nxt;
  logic             w_err_dz;
  logic             w_err_ovf;
  logic             w_last;

  // Start-time operand checks: a quotient that cannot fit in N bits is
  // exactly the case where the upper dividend half is not below the divisor.
  assign w_err_dz  = (divisor == '0);
  assign w_err_ovf = (dividend[2*N-1:N] >= divisor);

  // The partial remainder is always below the divisor, so its top bit is
  // zero and the shift never loses information.
  assign w_shift    = (r_prem << 1) | {{N{1'b0}}, r_dvd_lo[N-1]};
  assign w_prem_nxt = w_nonneg ? w_diff : w_shift;
  assign w_quo_nxt  = (r_qacc << 1) | {{(N-1){1'b0}}, w_nonneg};
  assign w_last     = (r_cnt == CNT_W'(N - 1));

  sub_trial #(
    .W (N + 1)
  ) u_sub_trial (
    .i_a      (w_shift),
    .i_b      ({1'b0, r_dvs}),
    .o_diff   (w_diff),
    .o_nonneg (w_nonneg)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (w_err_dz || w_err_ovf) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_dvd_lo <= '0;
      r_dvs    <= '0;
      r_prem   <= '0;
      r_qacc   <= '0;
      r_cnt    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_dz     <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_err_dz) begin
              r_dz  <= 1'b1;
              r_ovf <= 1'b0;
              r_quo <= '1;
              r_rem <= '0;
            end else if (w_err_ovf) begin
              r_dz  <= 1'b0;
              r_ovf <= 1'b1;
              r_quo <= '1;
              r_rem <= '0;
            end else begin
              r_dz     <= 1'b0;
              r_ovf    <= 1'b0;
              r_dvd_lo <= dividend[N-1:0];
              r_dvs    <= divisor;
              r_prem   <= {1'b0, dividend[2*N-1:N]};
              r_qacc   <= '0;
              r_cnt    <= '0;
            end
          end
        end
        S_RUN: begin
          r_prem   <= w_prem_nxt;
          r_dvd_lo <= r_dvd_lo << 1;
          r_qacc   <= w_quo_nxt;
          r_cnt    <= r_cnt + CNT_W'(1);
          // Visible results only change when the last step completes.
          if (w_last) begin
            r_quo <= w_quo_nxt;
            r_rem <= N'(w_prem_nxt);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign quo  = r_quo;
  assign rem  = r_rem;
  assign dz   = r_dz;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_div_10.sv
// Directed and randomized bench for div_10 with an arithmetic reference model.
module tb_div_10;

  localparam int N = 10;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [2*N-1:0] dividend = '0;
  logic [N-1:0]   divisor = '0;
  logic           busy;
  logic           done;
  logic [N-1:0]   quo;
  logic [N-1:0]   rem;
  logic           dz;
  logic           ovf;

  int total = 0;
  int bad = 0;

  div_10 #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quo      (quo),
    .rem      (rem),
    .dz       (dz),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one division, optionally with spurious start pulses while busy,
  // and compare latency and results against plain integer arithmetic.
  task automatic do_div(input longint dvd, input longint dvs, input bit noise);
    longint exp_q;
    longint exp_r;
    bit     exp_dz;
    bit     exp_ovf;
    int     exp_lat;
    int     cyc;

    exp_dz  = (dvs == 0);
    exp_ovf = !exp_dz && ((dvd / dvs) >= (1 << N));
    if (exp_dz || exp_ovf) begin
      exp_q   = (1 << N) - 1;
      exp_r   = 0;
      exp_lat = 0;
    end else begin
      exp_q   = dvd / dvs;
      exp_r   = dvd % dvs;
      exp_lat = N;
    end

    cyc = 0;
    @(negedge clk);
    while (busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("idle_before_start", busy, 0);

    dividend = dvd[2*N-1:0];
    divisor  = dvs[N-1:0];
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 20'($urandom);
    divisor  = 10'($urandom);

    cyc = 0;
    while (!done && cyc < 3 * N) begin
      if (noise && (cyc == 2 || cyc == 5)) begin
        start    = 1'b1;
        dividend = 20'($urandom);
        divisor  = 10'($urandom_range(0, 1023));
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
    end

    check("latency", cyc, exp_lat);
    check("done_pulse", done, 1);
    check("busy_in_done", busy, 1);
    check("quo", quo, exp_q);
    check("rem", rem, exp_r);
    check("dz", dz, exp_dz);
    check("ovf", ovf, exp_ovf);

    // A start presented during the done cycle must be ignored.
    dividend = 20'd1000;
    divisor  = 10'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_one_cycle", done, 0);
    check("start_in_done_ignored", busy, 0);
    check("quo_hold", quo, exp_q);
    check("rem_hold", rem, exp_r);
  endtask

  initial begin
    longint q;
    longint r;
    longint d;
    int     seen_done;

    rst_n = 1'b0;
    start = 1'b1;
    dividend = 20'd1000000;
    divisor  = 10'd1000;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quo", quo, 0);
    check("rst_rem", rem, 0);
    check("rst_dz", dz, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;

    do_div(1000000, 1000, 0);
    do_div(999999, 1000, 0);
    do_div(5000, 0, 0);
    do_div(7168, 7, 0);
    do_div(7167, 7, 0);
    do_div(0, 1, 0);
    do_div(1048575, 1023, 0);
    do_div(1047552, 1023, 0);
    do_div(123456, 789, 1);
    do_div(54321, 77, 0);

    // Reset in the middle of a run aborts it; a start sampled with reset
    // is also dropped.
    @(negedge clk);
    dividend = 20'd1000000;
    divisor  = 10'd1000;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("run_busy_before_reset", busy, 1);
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_quo", quo, 0);
    check("abort_rem", rem, 0);
    check("abort_done", done, 0);
    seen_done = 0;
    for (int i = 0; i < 2 * N; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen_done = 1;
    end
    check("abort_no_done", seen_done, 0);

    do_div(999999, 1000, 0);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0: begin
          d = 0;
          q = longint'($urandom_range(0, 1048575));
          do_div(q, d, i[0]);
        end
        1: begin
          d = longint'($urandom_range(1, 1023));
          q = longint'($urandom_range(1024, 2047));
          r = longint'($urandom_range(0, 32'(d - 1)));
          do_div((q * d + r) & 64'hFFFFF, d, i[0]);
        end
        default: begin
          d = longint'($urandom_range(1, 1023));
          q = longint'($urandom_range(0, 1023));
          r = longint'($urandom_range(0, 32'(d - 1)));
          do_div(q * d + r, d, i[0]);
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
